// File: rtl/rv32_insn_encoder_loader.sv
// RV32I field-bundle encoder and sequential instruction-memory loader (boot/debug injector).
// Each accepted bundle is encoded, then written with a single-cycle strobe at the next word address.
module rv32_insn_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [2:0]        in_func3,
  input  logic              in_alt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, ENC, WR, DONE} state_t;

  state_t             state_q;
  logic               we_q, done_q, err_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [ADDR_W:0]    count_q;
  logic [3:0]         cls_q;
  logic [2:0]         f3_q;
  logic               alt_q, last_q;
  logic [4:0]         rd_q, rs1_q, rs2_q;
  logic [31:0]        imm_q;
  logic [ADDR_W:0]    count_d;

  function automatic logic legal(input logic [3:0] cls, input logic [2:0] f3);
    legal = 1'b1;
    case (cls)
      4'd2:    legal = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
      4'd3:    legal = (f3 < 3'b011);
      4'd4:    legal = !(f3 == 3'b010 || f3 == 3'b011);
      default: legal = (cls <= 4'd8);
    endcase
  endfunction

  function automatic logic [31:0] encode(input logic [3:0] cls, input logic [2:0] f3, input logic alt,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [31:0] imm);
    logic [6:0]  f7;
    logic [11:0] i12;
    encode = 32'd0;
    f7     = (alt && (f3 == 3'b000 || f3 == 3'b101)) ? 7'h20 : 7'h00;
    // Shift-immediates carry alt in bit 30 and only a 5-bit shamt.
    i12    = (f3 == 3'b001 || f3 == 3'b101) ? {1'b0, alt, 5'b00000, imm[4:0]} : imm[11:0];
    case (cls)
      4'd0: encode = {f7, rs2, rs1, f3, rd, 7'b0110011};
      4'd1: encode = {i12, rs1, f3, rd, 7'b0010011};
      4'd2: encode = {imm[11:0], rs1, f3, rd, 7'b0000011};
      4'd3: encode = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      4'd4: encode = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
      4'd5: encode = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      4'd6: encode = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      4'd7: encode = {imm[31:12], rd, 7'b0110111};
      4'd8: encode = {imm[31:12], rd, 7'b0010111};
      default: encode = 32'd0;
    endcase
  endfunction

  assign count_d = count_q + CNT_ONE;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= BASE;
      wdata_q <= 32'd0;
      count_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            cls_q   <= in_class;
            f3_q    <= in_func3;
            alt_q   <= in_alt;
            rd_q    <= in_rd;
            rs1_q   <= in_rs1;
            rs2_q   <= in_rs2;
            imm_q   <= in_imm;
            last_q  <= in_last;
            state_q <= ENC;
          end
        end
        ENC: begin
          if (legal(cls_q, f3_q)) begin
            wdata_q <= encode(cls_q, f3_q, alt_q, rd_q, rs1_q, rs2_q, imm_q);
            we_q    <= 1'b1;
            state_q <= WR;
          end else begin
            err_q   <= 1'b1;
            done_q  <= last_q;
            state_q <= last_q ? DONE : IDLE;
          end
        end
        WR: begin
          we_q    <= 1'b0;
          addr_q  <= addr_q + ADDR_ONE;
          count_q <= count_d;
          if (last_q || count_d == FULL_CNT) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= DONE;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE) && !full && !done_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign full       = (count_q == FULL_CNT);
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_rv32_insn_encoder_loader.sv
// Bench for rv32_insn_encoder_loader: directed bundles, an arithmetic encoding model feeding a
// write scoreboard, and a small ADDR_W=2 instance for the full/done path.
module tb_rv32_insn_encoder_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, clear = 1'b0;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic [3:0]  cls = '0;
  logic [2:0]  f3 = '0;
  logic        alt = 1'b0, last = 1'b0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0;

  logic        rdy_a, we_a, full_a, done_a, err_a;
  logic [7:0]  addr_a;
  logic [31:0] wd_a;
  logic [8:0]  cnt_a;
  logic        rdy_b, we_b, full_b, done_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wd_b;
  logic [2:0]  cnt_b;

  rv32_insn_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(valid_a), .in_ready(rdy_a),
    .in_class(cls), .in_func3(f3), .in_alt(alt), .in_rd(rd), .in_rs1(rs1), .in_rs2(rs2),
    .in_imm(imm), .in_last(last), .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wd_a),
    .count(cnt_a), .full(full_a), .done(done_a), .err(err_a));

  rv32_insn_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(valid_b), .in_ready(rdy_b),
    .in_class(cls), .in_func3(f3), .in_alt(alt), .in_rd(rd), .in_rs1(rs1), .in_rs2(rs2),
    .in_imm(imm), .in_last(last), .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wd_b),
    .count(cnt_b), .full(full_b), .done(done_b), .err(err_b));

  int checks = 0, errors = 0;
  int nwr_a = 0, nwr_b = 0;
  logic [31:0] last_wd_a = '0;
  logic        prev_we_a = 1'b0, prev_we_b = 1'b0;
  logic [39:0] qa[$], qb[$];
  logic [7:0]  maddr_a = '0;
  logic [1:0]  maddr_b = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Encoding built from instruction-format bit positions with plain arithmetic.
  function automatic logic [31:0] mdl(input logic [3:0] c, input logic [2:0] f, input logic a,
                                      input logic [4:0] d, input logic [4:0] s1,
                                      input logic [4:0] s2, input logic [31:0] im);
    logic [31:0] D, F, S1, S2, i12;
    D = 32'(d); F = 32'(f); S1 = 32'(s1); S2 = 32'(s2);
    i12 = (f == 3'd1 || f == 3'd5) ? ((a ? 32'h400 : 32'h0) + (im & 32'h1F)) : (im & 32'hFFF);
    case (c)
      4'd0: mdl = 32'h33 + (D << 7) + (F << 12) + (S1 << 15) + (S2 << 20)
                  + ((a && (f == 3'd0 || f == 3'd5)) ? 32'h4000_0000 : 32'h0);
      4'd1: mdl = 32'h13 + (D << 7) + (F << 12) + (S1 << 15) + (i12 << 20);
      4'd2: mdl = 32'h03 + (D << 7) + (F << 12) + (S1 << 15) + ((im & 32'hFFF) << 20);
      4'd3: mdl = 32'h23 + ((im & 32'h1F) << 7) + (F << 12) + (S1 << 15) + (S2 << 20)
                  + (((im >> 5) & 32'h7F) << 25);
      4'd4: mdl = 32'h63 + (((im >> 11) & 32'h1) << 7) + (((im >> 1) & 32'hF) << 8) + (F << 12)
                  + (S1 << 15) + (S2 << 20) + (((im >> 5) & 32'h3F) << 25) + (((im >> 12) & 32'h1) << 31);
      4'd5: mdl = 32'h6F + (D << 7) + (((im >> 12) & 32'hFF) << 12) + (((im >> 11) & 32'h1) << 20)
                  + (((im >> 1) & 32'h3FF) << 21) + (((im >> 20) & 32'h1) << 31);
      4'd6: mdl = 32'h67 + (D << 7) + (S1 << 15) + ((im & 32'hFFF) << 20);
      4'd7: mdl = 32'h37 + (D << 7) + (im & 32'hFFFF_F000);
      4'd8: mdl = 32'h17 + (D << 7) + (im & 32'hFFFF_F000);
      default: mdl = 32'h0;
    endcase
  endfunction

  function automatic bit mlegal(input logic [3:0] c, input logic [2:0] f);
    if (c > 4'd8) return 1'b0;
    if (c == 4'd4 && (f == 3'd2 || f == 3'd3)) return 1'b0;
    if (c == 4'd2 && (f == 3'd3 || f >= 3'd6)) return 1'b0;
    if (c == 4'd3 && f >= 3'd3) return 1'b0;
    return 1'b1;
  endfunction

  // Scoreboard: every write strobe must match the oldest expected write, never back-to-back.
  always @(negedge clk) begin
    logic [39:0] e;
    if (we_a) begin
      chk("wr_pending_a", 32'(qa.size() != 0), 32'd1);
      chk("we_gap_a", 32'(prev_we_a), 32'd0);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("wr_addr_a", 32'(addr_a), 32'(e[39:32]));
        chk("wr_data_a", wd_a, e[31:0]);
      end
      last_wd_a = wd_a;
      nwr_a++;
    end
    if (we_b) begin
      chk("wr_pending_b", 32'(qb.size() != 0), 32'd1);
      chk("we_gap_b", 32'(prev_we_b), 32'd0);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("wr_addr_b", 32'(addr_b), 32'(e[33:32]));
        chk("wr_data_b", wd_b, e[31:0]);
      end
      nwr_b++;
    end
    prev_we_a = we_a;
    prev_we_b = we_b;
  end

  task automatic send(input bit b, input logic [3:0] c, input logic [2:0] f, input logic a,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [31:0] im, input logic l, input bit exp_acc);
    int  n = 0;
    bit  acc;
    @(negedge clk);
    while (!(b ? rdy_b : rdy_a) && n < 30) begin
      @(negedge clk);
      n++;
    end
    acc = b ? rdy_b : rdy_a;
    chk("accepted", 32'(acc), 32'(exp_acc));
    if (acc) begin
      cls = c; f3 = f; alt = a; rd = d; rs1 = s1; rs2 = s2; imm = im; last = l;
      if (mlegal(c, f)) begin
        if (b) begin qb.push_back({6'b0, maddr_b, mdl(c, f, a, d, s1, s2, im)}); maddr_b++; end
        else   begin qa.push_back({maddr_a, mdl(c, f, a, d, s1, s2, im)}); maddr_a++; end
      end
      if (b) valid_b = 1'b1; else valid_a = 1'b1;
      @(posedge clk);
      #1;
      valid_a = 1'b0;
      valid_b = 1'b0;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    cycles(4);
    chk("queue_drained_a", 32'(qa.size()), 32'd0);
    chk("queue_drained_b", 32'(qb.size()), 32'd0);
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    maddr_a = '0;
    maddr_b = '0;
  endtask

  initial begin
    int n0, k;
    // Model pins: hand-assembled words.
    chk("mdl_addi", mdl(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5), 32'h0050_0093);
    chk("mdl_sub",  mdl(4'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0), 32'h4020_81B3);
    chk("mdl_sw",   mdl(4'd3, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8), 32'h0020_A423);
    chk("mdl_beq",  mdl(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC), 32'hFE20_8EE3);
    chk("mdl_jal",  mdl(4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8), 32'h0080_00EF);
    chk("mdl_lui",  mdl(4'd7, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000), 32'h1234_52B7);
    chk("mdl_srai", mdl(4'd1, 3'd5, 1'b1, 5'd4, 5'd4, 5'd0, 32'd3), 32'h4032_5213);

    cycles(2);
    rst = 1'b0;
    cycles(1);
    chk("rst_ready", 32'(rdy_a), 32'd1);
    chk("rst_we",    32'(we_a), 32'd0);
    chk("rst_addr",  32'(addr_a), 32'd0);
    chk("rst_wdata", wd_a, 32'd0);
    chk("rst_count", 32'(cnt_a), 32'd0);
    chk("rst_flags", {29'd0, full_a, done_a, err_a}, 32'd0);

    // ADDI x1,x0,5
    send(1'b0, 4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1);
    cycles(4);
    chk("addi_count", 32'(cnt_a), 32'd1);
    chk("addi_word", last_wd_a, 32'h0050_0093);
    chk("addi_writes", 32'(nwr_a), 32'd1);
    do_clear();
    chk("clear_count", 32'(cnt_a), 32'd0);

    // SUB x3,x1,x2 ; SW x2,8(x1) last
    send(1'b0, 4'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1);
    send(1'b0, 4'd3, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 1'b1);
    cycles(4);
    chk("sw_word", last_wd_a, 32'h0020_A423);
    chk("last_done", 32'(done_a), 32'd1);
    chk("last_ready", 32'(rdy_a), 32'd0);
    chk("last_count", 32'(cnt_a), 32'd2);
    do_clear();

    // Branch, jumps, upper-immediate, shifts, alt-ignored ALU op
    send(1'b0, 4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0, 1'b1);
    send(1'b0, 4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0, 1'b1);
    send(1'b0, 4'd7, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0, 1'b1);
    cycles(4);
    chk("lui_word", last_wd_a, 32'h1234_52B7);
    send(1'b0, 4'd1, 3'd5, 1'b1, 5'd4, 5'd4, 5'd0, 32'hFFFF_FFE3, 1'b0, 1'b1);
    send(1'b0, 4'd0, 3'd1, 1'b1, 5'd6, 5'd7, 5'd8, 32'd0, 1'b0, 1'b1);
    send(1'b0, 4'd6, 3'd7, 1'b0, 5'd1, 5'd9, 5'd0, 32'h0000_1F04, 1'b0, 1'b1);
    send(1'b0, 4'd8, 3'd0, 1'b0, 5'd31, 5'd0, 5'd0, 32'hABCD_EFFF, 1'b0, 1'b1);
    send(1'b0, 4'd2, 3'd4, 1'b0, 5'd10, 5'd11, 5'd0, 32'hFFFF_F800, 1'b0, 1'b1);
    cycles(4);
    chk("mix_count", 32'(cnt_a), 32'd8);
    do_clear();

    // Illegal class between two ADDIs
    n0 = nwr_a;
    send(1'b0, 4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1);
    send(1'b0, 4'd12, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1);
    send(1'b0, 4'd1, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd7, 1'b0, 1'b1);
    cycles(4);
    chk("ill_err", 32'(err_a), 32'd1);
    chk("ill_count", 32'(cnt_a), 32'd2);
    chk("ill_writes", 32'(nwr_a - n0), 32'd2);
    do_clear();
    chk("clear_err", 32'(err_a), 32'd0);

    // ADDR_W=2: fill the memory, fifth bundle refused
    for (k = 0; k < 5; k++)
      send(1'b1, 4'd1, 3'd0, 1'b0, 5'(k + 1), 5'd0, 5'd0, 32'(k), 1'b0, k < 4);
    cycles(4);
    chk("full_writes", 32'(nwr_b), 32'd4);
    chk("full_flag", 32'(full_b), 32'd1);
    chk("full_done", 32'(done_b), 32'd1);
    chk("full_count", 32'(cnt_b), 32'd4);
    chk("full_ready", 32'(rdy_b), 32'd0);
    do_clear();
    chk("wrap_addr", 32'(addr_b), 32'd0);

    // Reset during the write cycle
    send(1'b0, 4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1);
    n0 = 0;
    while (!we_a && n0 < 10) begin
      cycles(1);
      n0++;
    end
    chk("wr_seen", 32'(we_a), 32'd1);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    maddr_a = '0;
    maddr_b = '0;
    chk("rstwr_we", 32'(we_a), 32'd0);
    chk("rstwr_count", 32'(cnt_a), 32'd0);
    chk("rstwr_addr", 32'(addr_a), 32'd0);
    send(1'b0, 4'd1, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd9, 1'b0, 1'b1);
    cycles(4);
    chk("rstwr_count2", 32'(cnt_a), 32'd1);
    chk("final_queue_a", 32'(qa.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
